// File: rtl/sal_cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// sal_cmd_sched_pkg
// Shared SAL definitions for the DRAM command path: field-width macros for the
// DRAM address/AXI tag fields and the inter-bank timing registers, plus the
// DFI command-type encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef SAL_CMD_SCHED_DEFINES
`define SAL_CMD_SCHED_DEFINES
`define DRAM_BA_WIDTH 2
`define DRAM_RA_WIDTH 14
`define DRAM_CA_WIDTH 10
`define AXI_ID_WIDTH  4
`define AXI_LEN_WIDTH 8
`define T_RRD_WIDTH   4
`define T_CCD_WIDTH   4
`define T_WTR_WIDTH   4
`define T_RTW_WIDTH   4
`endif

package sal_cmd_sched_pkg;

   localparam int CMD_W = 3;

   // Encoding seen on the DFI-side command bus.
   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } sal_cmd_e;

endpackage

// File: rtl/sal_cmd_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// sal_rr_arb
// Combinational round-robin arbiter. Scans the request vector starting at the
// bank given by ptr and grants the first requester found.
// Ports:
//   req  in  BK_CNT  request per bank
//   ptr  in  PW      bank with highest priority this cycle
//   gnt  out BK_CNT  one-hot grant (all zero when no request)
//   idx  out PW      index of the granted bank (0 when none)
//   any  out 1       at least one request present
// -----------------------------------------------------------------------------
module sal_rr_arb #(
   parameter int BK_CNT = 4,
   parameter int PW     = (BK_CNT > 1) ? $clog2(BK_CNT) : 1
) (
   input  logic [BK_CNT-1:0] req,
   input  logic [PW-1:0]     ptr,
   output logic [BK_CNT-1:0] gnt,
   output logic [PW-1:0]     idx,
   output logic              any
);

   int          pos;
   logic [PW-1:0] cand;

   // Rotating priority scan: first requester at or after ptr wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      pos  = 0;
      cand = '0;
      for (int i = 0; i < BK_CNT; i++) begin
         pos  = (int'(ptr) + i) % BK_CNT;
         cand = PW'(pos);
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/sal_cmd_sched.sv
// -----------------------------------------------------------------------------
// sal_cmd_sched
// Per-channel DRAM command scheduler. Grants at most one bank command per
// cycle (class priority CAS > ACT > PRE > REF, round-robin inside a class),
// enforces tRRD/tCCD/tWTR/tRTW between banks and drives a registered command
// bus one cycle after the grant.
// Ports:
//   clk, rst                          clock, async active-high reset
//   t_rrd_m1/t_ccd_m1/t_wtr_m1/t_rtw_m1  timing values minus one
//   act/rd/wr/pre/ref_req  [BK_CNT]   level requests, bit b = bank b
//   ra/ca/id/len                       per-bank fields, slice b = bank b
//   act/rd/wr/pre/ref_gnt  [BK_CNT]   combinational grants (at most one bit)
//   cmd_valid, cmd_type, cmd_ba/ra/ca/id/len  registered command
// -----------------------------------------------------------------------------
module sal_cmd_sched
   import sal_cmd_sched_pkg::*;
#(
   parameter int BK_CNT = 1 << `DRAM_BA_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [`T_RRD_WIDTH-1:0]            t_rrd_m1,
   input  logic [`T_CCD_WIDTH-1:0]            t_ccd_m1,
   input  logic [`T_WTR_WIDTH-1:0]            t_wtr_m1,
   input  logic [`T_RTW_WIDTH-1:0]            t_rtw_m1,
   input  logic [BK_CNT-1:0]                  act_req,
   input  logic [BK_CNT-1:0]                  rd_req,
   input  logic [BK_CNT-1:0]                  wr_req,
   input  logic [BK_CNT-1:0]                  pre_req,
   input  logic [BK_CNT-1:0]                  ref_req,
   input  logic [BK_CNT*`DRAM_RA_WIDTH-1:0]   ra,
   input  logic [BK_CNT*`DRAM_CA_WIDTH-1:0]   ca,
   input  logic [BK_CNT*`AXI_ID_WIDTH-1:0]    id,
   input  logic [BK_CNT*`AXI_LEN_WIDTH-1:0]   len,
   output logic [BK_CNT-1:0]                  act_gnt,
   output logic [BK_CNT-1:0]                  rd_gnt,
   output logic [BK_CNT-1:0]                  wr_gnt,
   output logic [BK_CNT-1:0]                  pre_gnt,
   output logic [BK_CNT-1:0]                  ref_gnt,
   output logic                               cmd_valid,
   output logic [CMD_W-1:0]                   cmd_type,
   output logic [`DRAM_BA_WIDTH-1:0]          cmd_ba,
   output logic [`DRAM_RA_WIDTH-1:0]          cmd_ra,
   output logic [`DRAM_CA_WIDTH-1:0]          cmd_ca,
   output logic [`AXI_ID_WIDTH-1:0]           cmd_id,
   output logic [`AXI_LEN_WIDTH-1:0]          cmd_len
);

   localparam int BA_W  = `DRAM_BA_WIDTH;
   localparam int RA_W  = `DRAM_RA_WIDTH;
   localparam int CA_W  = `DRAM_CA_WIDTH;
   localparam int ID_W  = `AXI_ID_WIDTH;
   localparam int LEN_W = `AXI_LEN_WIDTH;
   localparam int RRD_W = `T_RRD_WIDTH;
   localparam int CCD_W = `T_CCD_WIDTH;
   localparam int WTR_W = `T_WTR_WIDTH;
   localparam int RTW_W = `T_RTW_WIDTH;
   localparam int PW    = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

   // Next round-robin pointer: one past the granted bank, wrapping at BK_CNT.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] b);
      logic [PW-1:0] r;
      if (b == PW'(BK_CNT - 1)) begin
         r = '0;
      end else begin
         r = b + PW'(1);
      end
      return r;
   endfunction

   // Per-bank field views
   logic [RA_W-1:0]  ra_a  [BK_CNT];
   logic [CA_W-1:0]  ca_a  [BK_CNT];
   logic [ID_W-1:0]  id_a  [BK_CNT];
   logic [LEN_W-1:0] len_a [BK_CNT];

   for (genvar b = 0; b < BK_CNT; b++) begin : g_fields
      assign ra_a[b]  = ra[b*RA_W +: RA_W];
      assign ca_a[b]  = ca[b*CA_W +: CA_W];
      assign id_a[b]  = id[b*ID_W +: ID_W];
      assign len_a[b] = len[b*LEN_W +: LEN_W];
   end

   // State
   logic [RRD_W-1:0] rrd_cnt_q, rrd_cnt_d;
   logic [CCD_W-1:0] ccd_cnt_q, ccd_cnt_d;
   logic [WTR_W-1:0] wtr_cnt_q, wtr_cnt_d;
   logic [RTW_W-1:0] rtw_cnt_q, rtw_cnt_d;
   logic [PW-1:0]    act_ptr_q, act_ptr_d;
   logic [PW-1:0]    cas_ptr_q, cas_ptr_d;
   logic [PW-1:0]    pre_ptr_q, pre_ptr_d;
   logic [PW-1:0]    ref_ptr_q, ref_ptr_d;
   logic             cmd_valid_q, cmd_valid_d;
   sal_cmd_e         cmd_type_q, cmd_type_d;
   logic [BA_W-1:0]  cmd_ba_q, cmd_ba_d;
   logic [RA_W-1:0]  cmd_ra_q, cmd_ra_d;
   logic [CA_W-1:0]  cmd_ca_q, cmd_ca_d;
   logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
   logic [LEN_W-1:0] cmd_len_q, cmd_len_d;

   // Eligibility
   logic act_ok, rd_ok, wr_ok;
   logic [BK_CNT-1:0] cas_elig, act_elig;

   assign act_ok   = (rrd_cnt_q == '0);
   assign rd_ok    = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
   assign wr_ok    = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
   // RD and WR compete in one CAS class; each bank only ever raises one type.
   assign cas_elig = (rd_req & {BK_CNT{rd_ok}}) | (wr_req & {BK_CNT{wr_ok}});
   assign act_elig = act_req & {BK_CNT{act_ok}};

   // Per-class arbiters
   logic [BK_CNT-1:0] cas_oh, act_oh, pre_oh, ref_oh;
   logic [PW-1:0]     cas_idx, act_idx, pre_idx, ref_idx;
   logic              cas_any, act_any, pre_any, ref_any;

   sal_rr_arb #(.BK_CNT(BK_CNT), .PW(PW)) u_cas_arb (
      .req(cas_elig), .ptr(cas_ptr_q), .gnt(cas_oh), .idx(cas_idx), .any(cas_any));
   sal_rr_arb #(.BK_CNT(BK_CNT), .PW(PW)) u_act_arb (
      .req(act_elig), .ptr(act_ptr_q), .gnt(act_oh), .idx(act_idx), .any(act_any));
   sal_rr_arb #(.BK_CNT(BK_CNT), .PW(PW)) u_pre_arb (
      .req(pre_req),  .ptr(pre_ptr_q), .gnt(pre_oh), .idx(pre_idx), .any(pre_any));
   sal_rr_arb #(.BK_CNT(BK_CNT), .PW(PW)) u_ref_arb (
      .req(ref_req),  .ptr(ref_ptr_q), .gnt(ref_oh), .idx(ref_idx), .any(ref_any));

   sal_cmd_e      sel_type;
   logic [PW-1:0] sel_bank;

   // Class priority: a stalled higher class falls through to the next one.
   always_comb begin
      sel_type = CMD_NOP;
      sel_bank = '0;
      if (rst) begin
         sel_type = CMD_NOP;
      end else if (cas_any) begin
         sel_bank = cas_idx;
         sel_type = rd_req[cas_idx] ? CMD_RD : CMD_WR;
      end else if (act_any) begin
         sel_bank = act_idx;
         sel_type = CMD_ACT;
      end else if (pre_any) begin
         sel_bank = pre_idx;
         sel_type = CMD_PRE;
      end else if (ref_any) begin
         sel_bank = ref_idx;
         sel_type = CMD_REF;
      end else begin
         sel_type = CMD_NOP;
      end
   end

   // Route the winning class's one-hot to its grant vector.
   always_comb begin
      act_gnt = '0;
      rd_gnt  = '0;
      wr_gnt  = '0;
      pre_gnt = '0;
      ref_gnt = '0;
      case (sel_type)
         CMD_ACT: act_gnt = act_oh;
         CMD_RD:  rd_gnt  = cas_oh;
         CMD_WR:  wr_gnt  = cas_oh;
         CMD_PRE: pre_gnt = pre_oh;
         CMD_REF: ref_gnt = ref_oh;
         default: begin
         end
      endcase
   end

   // Next-state: timing counters, pointers and the command register.
   always_comb begin
      rrd_cnt_d   = (rrd_cnt_q != '0) ? rrd_cnt_q - RRD_W'(1) : rrd_cnt_q;
      ccd_cnt_d   = (ccd_cnt_q != '0) ? ccd_cnt_q - CCD_W'(1) : ccd_cnt_q;
      wtr_cnt_d   = (wtr_cnt_q != '0) ? wtr_cnt_q - WTR_W'(1) : wtr_cnt_q;
      rtw_cnt_d   = (rtw_cnt_q != '0) ? rtw_cnt_q - RTW_W'(1) : rtw_cnt_q;
      act_ptr_d   = act_ptr_q;
      cas_ptr_d   = cas_ptr_q;
      pre_ptr_d   = pre_ptr_q;
      ref_ptr_d   = ref_ptr_q;
      cmd_valid_d = 1'b0;
      cmd_type_d  = CMD_NOP;
      cmd_ba_d    = cmd_ba_q;
      cmd_ra_d    = cmd_ra_q;
      cmd_ca_d    = cmd_ca_q;
      cmd_id_d    = cmd_id_q;
      cmd_len_d   = cmd_len_q;

      // A load on grant overrides the decrement above.
      case (sel_type)
         CMD_ACT: begin
            rrd_cnt_d = t_rrd_m1;
            act_ptr_d = ptr_inc(sel_bank);
         end
         CMD_RD: begin
            ccd_cnt_d = t_ccd_m1;
            rtw_cnt_d = t_rtw_m1;
            cas_ptr_d = ptr_inc(sel_bank);
         end
         CMD_WR: begin
            ccd_cnt_d = t_ccd_m1;
            wtr_cnt_d = t_wtr_m1;
            cas_ptr_d = ptr_inc(sel_bank);
         end
         CMD_PRE: pre_ptr_d = ptr_inc(sel_bank);
         CMD_REF: ref_ptr_d = ptr_inc(sel_bank);
         default: begin
         end
      endcase

      if (sel_type != CMD_NOP) begin
         cmd_valid_d = 1'b1;
         cmd_type_d  = sel_type;
         cmd_ba_d    = BA_W'(sel_bank);
         cmd_ra_d    = ra_a[sel_bank];
         cmd_ca_d    = ca_a[sel_bank];
         cmd_id_d    = id_a[sel_bank];
         cmd_len_d   = len_a[sel_bank];
      end else begin
         cmd_valid_d = 1'b0;
      end
   end

   // State registers; reset drops any command in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrd_cnt_q   <= '0;
         ccd_cnt_q   <= '0;
         wtr_cnt_q   <= '0;
         rtw_cnt_q   <= '0;
         act_ptr_q   <= '0;
         cas_ptr_q   <= '0;
         pre_ptr_q   <= '0;
         ref_ptr_q   <= '0;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= CMD_NOP;
         cmd_ba_q    <= '0;
         cmd_ra_q    <= '0;
         cmd_ca_q    <= '0;
         cmd_id_q    <= '0;
         cmd_len_q   <= '0;
      end else begin
         rrd_cnt_q   <= rrd_cnt_d;
         ccd_cnt_q   <= ccd_cnt_d;
         wtr_cnt_q   <= wtr_cnt_d;
         rtw_cnt_q   <= rtw_cnt_d;
         act_ptr_q   <= act_ptr_d;
         cas_ptr_q   <= cas_ptr_d;
         pre_ptr_q   <= pre_ptr_d;
         ref_ptr_q   <= ref_ptr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_type_q  <= cmd_type_d;
         cmd_ba_q    <= cmd_ba_d;
         cmd_ra_q    <= cmd_ra_d;
         cmd_ca_q    <= cmd_ca_d;
         cmd_id_q    <= cmd_id_d;
         cmd_len_q   <= cmd_len_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_type  = cmd_type_q;
   assign cmd_ba    = cmd_ba_q;
   assign cmd_ra    = cmd_ra_q;
   assign cmd_ca    = cmd_ca_q;
   assign cmd_id    = cmd_id_q;
   assign cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_sal_cmd_sched
// Randomized bench for sal_cmd_sched. Banks are modelled as holding one
// pending request each until granted; a reference model tracks the earliest
// cycle each timing constraint allows and picks the winner by class priority
// and per-class rotation, then predicts the registered command bus.
// -----------------------------------------------------------------------------
module tb_sal_cmd_sched;

   localparam int BK    = 1 << `DRAM_BA_WIDTH;
   localparam int BA_W  = `DRAM_BA_WIDTH;
   localparam int RA_W  = `DRAM_RA_WIDTH;
   localparam int CA_W  = `DRAM_CA_WIDTH;
   localparam int ID_W  = `AXI_ID_WIDTH;
   localparam int LEN_W = `AXI_LEN_WIDTH;

   logic clk = 1'b0;
   logic rst;
   logic [`T_RRD_WIDTH-1:0] t_rrd_m1;
   logic [`T_CCD_WIDTH-1:0] t_ccd_m1;
   logic [`T_WTR_WIDTH-1:0] t_wtr_m1;
   logic [`T_RTW_WIDTH-1:0] t_rtw_m1;
   logic [BK-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
   logic [BK*RA_W-1:0]  ra;
   logic [BK*CA_W-1:0]  ca;
   logic [BK*ID_W-1:0]  id;
   logic [BK*LEN_W-1:0] len;
   logic [BK-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
   logic          cmd_valid;
   logic [2:0]    cmd_type;
   logic [BA_W-1:0]  cmd_ba;
   logic [RA_W-1:0]  cmd_ra;
   logic [CA_W-1:0]  cmd_ca;
   logic [ID_W-1:0]  cmd_id;
   logic [LEN_W-1:0] cmd_len;

   sal_cmd_sched #(.BK_CNT(BK)) dut (
      .clk(clk), .rst(rst),
      .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
      .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
      .ra(ra), .ca(ca), .id(id), .len(len),
      .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
      .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_ra(cmd_ra),
      .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Bank-side model: 0 = idle, else the command type held (1=ACT..5=REF).
   int               pend [BK];
   logic [RA_W-1:0]  pra  [BK];
   logic [CA_W-1:0]  pca  [BK];
   logic [ID_W-1:0]  pid  [BK];
   logic [LEN_W-1:0] plen [BK];

   // Timing values and earliest-allowed cycle per constraint.
   int t_rrd, t_ccd, t_wtr, t_rtw;
   int cyc;
   int rrd_nx, ccd_nx, wtr_nx, rtw_nx;
   int act_ptr, cas_ptr, pre_ptr, ref_ptr;
   int eg_t, eg_b;

   // Expected registered command.
   logic             e_valid;
   int               e_type;
   logic [BA_W-1:0]  e_ba;
   logic [RA_W-1:0]  e_ra;
   logic [CA_W-1:0]  e_ca;
   logic [ID_W-1:0]  e_id;
   logic [LEN_W-1:0] e_len;

   task automatic check_val(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
      n_checks++;
      if (obs_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs_v, exp_v, $time);
      end
   endtask

   task automatic drive_inputs();
      t_rrd_m1 = `T_RRD_WIDTH'(t_rrd);
      t_ccd_m1 = `T_CCD_WIDTH'(t_ccd);
      t_wtr_m1 = `T_WTR_WIDTH'(t_wtr);
      t_rtw_m1 = `T_RTW_WIDTH'(t_rtw);
      for (int b = 0; b < BK; b++) begin
         act_req[b] = (pend[b] == 1);
         rd_req[b]  = (pend[b] == 2);
         wr_req[b]  = (pend[b] == 3);
         pre_req[b] = (pend[b] == 4);
         ref_req[b] = (pend[b] == 5);
         ra[b*RA_W +: RA_W]    = pra[b];
         ca[b*CA_W +: CA_W]    = pca[b];
         id[b*ID_W +: ID_W]    = pid[b];
         len[b*LEN_W +: LEN_W] = plen[b];
      end
   endtask

   task automatic model_reset();
      rrd_nx = 0; ccd_nx = 0; wtr_nx = 0; rtw_nx = 0;
      act_ptr = 0; cas_ptr = 0; pre_ptr = 0; ref_ptr = 0;
      e_valid = 1'b0; e_type = 0;
      e_ba = '0; e_ra = '0; e_ca = '0; e_id = '0; e_len = '0;
   endtask

   // First bank at or after ptr holding type ta (allowed when oka) or tb2 (okb).
   function automatic int scan(input int ta, input int tb2, input int ptr, input bit oka, input bit okb);
      int bb;
      for (int k = 0; k < BK; k++) begin
         bb = (ptr + k) % BK;
         if ((pend[bb] == ta && oka) || (pend[bb] == tb2 && okb)) return bb;
      end
      return -1;
   endfunction

   task automatic eval_grant();
      bit act_ok, rd_ok, wr_ok;
      int b, t, n, ot, ob;
      act_ok = (cyc >= rrd_nx);
      rd_ok  = (cyc >= ccd_nx) && (cyc >= wtr_nx);
      wr_ok  = (cyc >= ccd_nx) && (cyc >= rtw_nx);
      t = 0;
      b = scan(2, 3, cas_ptr, rd_ok, wr_ok);
      if (b >= 0) t = pend[b];
      else begin
         b = scan(1, 1, act_ptr, act_ok, act_ok);
         if (b >= 0) t = 1;
         else begin
            b = scan(4, 4, pre_ptr, 1'b1, 1'b1);
            if (b >= 0) t = 4;
            else begin
               b = scan(5, 5, ref_ptr, 1'b1, 1'b1);
               if (b >= 0) t = 5;
            end
         end
      end
      if (t == 0) b = 0;
      n = 0; ot = 0; ob = 0;
      for (int bb = 0; bb < BK; bb++) begin
         if (act_gnt[bb]) begin n++; ot = 1; ob = bb; end
         if (rd_gnt[bb])  begin n++; ot = 2; ob = bb; end
         if (wr_gnt[bb])  begin n++; ot = 3; ob = bb; end
         if (pre_gnt[bb]) begin n++; ot = 4; ob = bb; end
         if (ref_gnt[bb]) begin n++; ot = 5; ob = bb; end
      end
      check_val("gnt_count", 64'(n), (t != 0) ? 64'd1 : 64'd0);
      check_val("gnt_type_bank", 64'(ot * 16 + ob), 64'(t * 16 + b));
      eg_t = t;
      eg_b = b;
   endtask

   // Apply the predicted grant as the clock edge would.
   task automatic commit();
      if (eg_t != 0) begin
         e_valid = 1'b1;
         e_type  = eg_t;
         e_ba    = BA_W'(eg_b);
         e_ra    = pra[eg_b];
         e_ca    = pca[eg_b];
         e_id    = pid[eg_b];
         e_len   = plen[eg_b];
         pend[eg_b] = 0;
         case (eg_t)
            1: begin act_ptr = (eg_b + 1) % BK; rrd_nx = cyc + t_rrd + 1; end
            2: begin cas_ptr = (eg_b + 1) % BK; ccd_nx = cyc + t_ccd + 1; rtw_nx = cyc + t_rtw + 1; end
            3: begin cas_ptr = (eg_b + 1) % BK; ccd_nx = cyc + t_ccd + 1; wtr_nx = cyc + t_wtr + 1; end
            4: pre_ptr = (eg_b + 1) % BK;
            5: ref_ptr = (eg_b + 1) % BK;
            default: ;
         endcase
      end else begin
         e_valid = 1'b0;
         e_type  = 0;
      end
      cyc++;
   endtask

   task automatic check_cmd();
      check_val("cmd_valid", 64'(cmd_valid), 64'(e_valid));
      check_val("cmd_type",  64'(cmd_type),  64'(e_type));
      check_val("cmd_ba",    64'(cmd_ba),    64'(e_ba));
      check_val("cmd_ra",    64'(cmd_ra),    64'(e_ra));
      check_val("cmd_ca",    64'(cmd_ca),    64'(e_ca));
      check_val("cmd_id",    64'(cmd_id),    64'(e_id));
      check_val("cmd_len",   64'(cmd_len),   64'(e_len));
   endtask

   task automatic step(input bit do_rand);
      @(posedge clk);
      #1;
      check_cmd();
      if (do_rand) begin
         for (int b = 0; b < BK; b++) begin
            if (pend[b] == 0 && $urandom_range(1, 0) == 1) begin
               pend[b] = int'($urandom_range(5, 1));
               pra[b]  = RA_W'($urandom);
               pca[b]  = CA_W'($urandom);
               pid[b]  = ID_W'($urandom);
               plen[b] = LEN_W'($urandom);
            end
         end
      end
      drive_inputs();
      #1;
      eval_grant();
   endtask

   // Reset asserted mid-cycle: outputs and grants must clear immediately.
   task automatic rst_assert_mid();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_cmd();
      check_val("gnt_in_rst", 64'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}), 64'd0);
   endtask

   task automatic rst_release();
      @(posedge clk);
      #1;
      check_cmd();
      #2;
      rst = 1'b0;
      drive_inputs();
      #1;
      eval_grant();
   endtask

   initial begin
      rst = 1'b1;
      t_rrd = 0; t_ccd = 0; t_wtr = 0; t_rtw = 0;
      cyc = 0;
      eg_t = 0; eg_b = 0;
      for (int b = 0; b < BK; b++) begin
         pend[b] = 0; pra[b] = '0; pca[b] = '0; pid[b] = '0; plen[b] = '0;
      end
      model_reset();
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_cmd();
      check_val("gnt_reset", 64'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}), 64'd0);
      rst_release();
      commit();

      // Randomized traffic phases with different timing sets.
      for (int p = 0; p < 8; p++) begin
         rst_assert_mid();
         if (p == 0) begin
            t_rrd = 0; t_ccd = 0; t_wtr = 0; t_rtw = 0;
         end else if (p == 1) begin
            t_rrd = 15; t_ccd = 15; t_wtr = 15; t_rtw = 15;
         end else begin
            t_rrd = int'($urandom_range(7, 0));
            t_ccd = int'($urandom_range(7, 0));
            t_wtr = int'($urandom_range(7, 0));
            t_rtw = int'($urandom_range(7, 0));
         end
         rst_release();
         commit();
         for (int c = 0; c < 150; c++) begin
            step(1'b1);
            if ($urandom_range(99, 0) == 0) begin
               rst_assert_mid();
               rst_release();
            end
            commit();
         end
      end

      // Reset while tRTW is counting: WR must be eligible straight after release.
      rst_assert_mid();
      t_rrd = 0; t_ccd = 0; t_wtr = 0; t_rtw = 7;
      for (int b = 0; b < BK; b++) pend[b] = 0;
      rst_release();
      commit();
      pend[0] = 2;
      step(1'b0);
      check_val("rd_directed", 64'(rd_gnt), 64'd1);
      commit();
      pend[1] = 3;
      repeat (3) begin
         step(1'b0);
         check_val("wr_blocked_rtw", 64'(wr_gnt), 64'd0);
         commit();
      end
      step(1'b0);
      check_val("wr_blocked_rtw", 64'(wr_gnt), 64'd0);
      rst_assert_mid();
      rst_release();
      check_val("wr_after_rst", 64'(wr_gnt), 64'd2);
      commit();
      step(1'b0);
      commit();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sal_cmd_sched.md
# sal_cmd_sched

Per-channel DRAM command scheduler between the per-bank controllers and the DFI command path. Each bank raises ACT/RD/WR/PRE/REF requests on its scheduler port. This block grants at most one bank command per cycle, enforcing inter-bank timing (tRRD, tCCD, tWTR, tRTW) from the timing register block, and issues the granted command on a registered command bus.

## Interface
- BK_CNT, default 1<<`DRAM_BA_WIDTH: number of banks / requesters
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- t_rrd_m1 / t_ccd_m1 / t_wtr_m1 / t_rtw_m1  in  `T_*_WIDTH  timing minus one; static while traffic flows
- act_req / rd_req / wr_req / pre_req / ref_req  in  BK_CNT  per-bank request, bit b = bank b
- ra  in  BK_CNT*`DRAM_RA_WIDTH; ca  in  BK_CNT*`DRAM_CA_WIDTH; id  in  BK_CNT*`AXI_ID_WIDTH; len  in  BK_CNT*`AXI_LEN_WIDTH: per-bank fields, slice b
- act_gnt / rd_gnt / wr_gnt / pre_gnt / ref_gnt  out  BK_CNT  combinational grant, at most one bit set across all five vectors
- cmd_valid  out  1  registered command strobe
- cmd_type  out  3  NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5
- cmd_ba  out  `DRAM_BA_WIDTH; cmd_ra / cmd_ca / cmd_id / cmd_len  out  field widths: registered command fields

## Operation
- Requests are level; a bank holds its req until the matching gnt. Each bank asserts at most one req type per cycle (bench assertion).
- Class priority: CAS (RD/WR) > ACT > PRE > REF. The winner is the highest-priority class with at least one eligible request.
- Within a class, round-robin over banks. Each class has its own pointer; on a grant in that class, pointer <= granted bank + 1 (mod BK_CNT). Pointers reset to 0.
- Eligibility:
  - ACT needs rrd_cnt==0.
  - RD needs ccd_cnt==0 and wtr_cnt==0.
  - WR needs ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF are always eligible.
- RD and WR share one CAS round-robin pointer.
- Counters, each saturating decrement by 1 per cycle down to 0:
  - ACT grant: rrd_cnt <= t_rrd_m1.
  - RD or WR grant: ccd_cnt <= t_ccd_m1.
  - WR grant: wtr_cnt <= t_wtr_m1.
  - RD grant: rtw_cnt <= t_rtw_m1.
  - Load takes precedence over decrement.
- An ineligible class does not block lower classes. Example: a CAS request stalled on tCCD lets a pending ACT win.

## Timing
- gnt is combinational in the request cycle N.
- In cycle N+1: cmd_valid=1, cmd_type set, and cmd_ba/ra/ca/id/len carry the granted bank's slice sampled at N.
- A cycle with no grant gives cmd_valid=0 and cmd_type=NOP next cycle. Fields hold their last value.
- Spacing: a grant at cycle N blocks the same constraint until cycle N+t_x_m1+1. With t_rrd_m1=3: ACT at 10, next ACT no earlier than 14.
- Reset (async assert, any cycle):
  - All counters, pointers and command outputs go to 0; cmd_type=NOP.
  - gnt vectors are 0 while rst is high.
  - A command in flight is dropped.
- t_*_m1=0 means back-to-back issue is allowed.

## Structure
- The command-type enum (NOP..REF) goes in the shared SAL package, next to the `T_*_WIDTH macros.
- Sub-module sal_rr_arb: parameterized BK_CNT round-robin arbiter (req vector, pointer in, one-hot gnt out), instantiated once per class (four instances).
- Timing counters and output registers live in sal_cmd_sched.

## Test plan
- Single bank 0: ACT, then RD held until granted, with t_ccd_m1=1 -> ACT at N, RD at N+1, cmd_valid at N+1/N+2, cmd_type 1 then 2, cmd_ba=0.
- All 4 banks hold act_req, t_rrd_m1=3 -> grants bank0,1,2,3 at cycles 0,4,8,12; wraps to bank0 if still requesting.
- WR bank1 at cycle 0, RD bank2 pending, t_wtr_m1=5, t_ccd_m1=1 -> RD granted at cycle 6, not earlier.
- CAS blocked by tCCD while bank3 requests PRE -> PRE granted in the blocked cycle, CAS granted on the first counter-zero cycle.
- Simultaneous RD/ACT/PRE/REF from four banks, all counters zero -> RD first, then ACT, PRE, REF on consecutive cycles.
- Assert rst mid-stream with rtw_cnt=4 -> all outputs 0 immediately; after release, WR is eligible at once.
